// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the core-side memory responder:
// MMIO map, reset instruction, status layout and read-path selects.
package cpu_mem_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;
  localparam logic [31:0] GPIO_ADDR  = MMIO_BASE + 32'h0;
  localparam logic [31:0] TX_ADDR    = MMIO_BASE + 32'h4;
  localparam logic [31:0] CYCLE_ADDR = MMIO_BASE + 32'h8;
  localparam logic [31:0] DROPS_ADDR = MMIO_BASE + 32'hC;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 8;

  typedef enum logic [1:0] {ISEL_NOP, ISEL_RAM, ISEL_ZERO} isel_e;
  typedef enum logic       {DSEL_REG, DSEL_RAM}            dsel_e;

  function automatic logic [31:0] tx_status(input logic empty, input logic full,
                                            input logic [ST_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_CNT_LSB +: ST_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Core-facing memory pins plus the TX consumer and GPIO, bundled as one bus.
interface cpu_mem_responder_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] gpio_out;

  modport master (
    output imem_addr, dmem_addr, dmem_wdata, dmem_wstrb, tx_ready,
    input  imem_rdata, dmem_rdata, tx_data, tx_valid, gpio_out
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_wdata, dmem_wstrb, tx_ready,
    output imem_rdata, dmem_rdata, tx_data, tx_valid, gpio_out
  );
endinterface

// File: rtl/cpu_mem_responder_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is refused
// even if a pop happens in the same cycle.
module tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_data = empty ? '0 : store[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !reset) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder beside the RV32I core: dual-port RAM with one-cycle
// registered reads on both ports, plus GPIO / TX FIFO / counters MMIO.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int    MEM_WORDS  = 4096,
  parameter string INIT_FILE  = "",
  parameter int    FIFO_DEPTH = 16
)(
  input  logic              clk,
  input  logic              reset,
  cpu_mem_responder_if.slave bus
);

  localparam int LANES  = 4;
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BYTE_W = IDX_W + 2;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [LANES-1:0][7:0] ram [MEM_WORDS];
  logic [LANES-1:0][7:0] wlanes, ird, drd, gpio;
  logic [IDX_W-1:0]      iidx, didx;
  logic                  i_ram, d_ram, ram_we;
  logic                  gpio_hit, tx_hit, cyc_hit, drop_hit;
  logic [31:0]           cycle_cnt, drop_cnt, mmio_rd, mmio_q;
  isel_e                 isel;
  dsel_e                 dsel;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0]      fifo_count;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.imem_addr[1:0], bus.dmem_addr[1:0]};

  assign wlanes = bus.dmem_wdata;
  assign iidx   = bus.imem_addr[BYTE_W-1:2];
  assign didx   = bus.dmem_addr[BYTE_W-1:2];
  assign i_ram  = bus.imem_addr[31:BYTE_W] == '0;
  assign d_ram  = bus.dmem_addr[31:BYTE_W] == '0;

  assign gpio_hit = bus.dmem_addr[31:2] == GPIO_ADDR[31:2];
  assign tx_hit   = bus.dmem_addr[31:2] == TX_ADDR[31:2];
  assign cyc_hit  = bus.dmem_addr[31:2] == CYCLE_ADDR[31:2];
  assign drop_hit = bus.dmem_addr[31:2] == DROPS_ADDR[31:2];

  assign ram_we = !reset && d_ram && (bus.dmem_wstrb != '0);

  // Non-blocking reads and writes in one process give read-first on both ports.
  always_ff @(posedge clk) begin
    ird <= ram[iidx];
    drd <= ram[didx];
    for (int l = 0; l < LANES; l++)
      if (ram_we && bus.dmem_wstrb[l]) ram[didx][l] <= wlanes[l];
  end

  always_comb begin
    mmio_rd = '0;
    if (gpio_hit)      mmio_rd = gpio;
    else if (tx_hit)   mmio_rd = tx_status(fifo_empty, fifo_full, ST_CNT_W'(fifo_count));
    else if (cyc_hit)  mmio_rd = cycle_cnt;
    else if (drop_hit) mmio_rd = drop_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      isel   <= ISEL_NOP;
      dsel   <= DSEL_REG;
      mmio_q <= '0;
    end else begin
      isel   <= i_ram ? ISEL_RAM : ISEL_ZERO;
      dsel   <= d_ram ? DSEL_RAM : DSEL_REG;
      mmio_q <= mmio_rd;
    end
  end

  always_comb begin
    case (isel)
      ISEL_RAM: bus.imem_rdata = ird;
      ISEL_NOP: bus.imem_rdata = NOP_INSTR;
      default:  bus.imem_rdata = '0;
    endcase
  end

  assign bus.dmem_rdata = (dsel == DSEL_RAM) ? drd : mmio_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio <= '0;
    end else if (gpio_hit) begin
      for (int l = 0; l < LANES; l++)
        if (bus.dmem_wstrb[l]) gpio[l] <= wlanes[l];
    end
  end

  assign bus.gpio_out = gpio;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (fifo_push && fifo_full && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign fifo_push = !reset && tx_hit && bus.dmem_wstrb[0];
  assign fifo_pop  = !fifo_empty && bus.tx_ready;

  tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (wlanes[0]),
    .pop       (fifo_pop),
    .pop_data  (bus.tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.tx_valid = !fifo_empty;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench: each driven cycle pushes the model's expected post-edge
// outputs; a monitor pops and compares them one cycle later.
module tb_cpu_mem_responder;
  import cpu_mem_pkg::*;

  localparam int          MEM_WORDS = 4096;
  localparam int          DEPTH     = 16;
  localparam logic [31:0] RAM_BYTES = MEM_WORDS * 4;
  localparam logic [31:0] IDLE      = 32'hFFFF_FFF0;

  logic clk, reset;
  cpu_mem_responder_if bus();

  cpu_mem_responder #(.MEM_WORDS(MEM_WORDS), .INIT_FILE(""), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    int unsigned tag;
    logic [31:0] im;  bit imk;
    logic [31:0] dm;  bit dmk;
    logic [31:0] gp;
    logic        tv;
    logic [7:0]  td;
  } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;

  // reference state: byte-addressed RAM (only bytes ever written), FIFO queue
  logic [7:0]  mbyte [int unsigned];
  logic [7:0]  mfifo [$];
  logic [31:0] mgpio = 0, mcyc = 0, mdrops = 0;
  bit          do_force = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, edges, act, exp);
    end
  endtask

  function automatic void mread(input logic [31:0] a, input bit ram_only,
                                output logic [31:0] v, output bit k);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    v = '0;
    k = 1;
    if (a < RAM_BYTES) begin
      for (int b = 0; b < 4; b++)
        if (mbyte.exists(w + b)) v[8*b +: 8] = mbyte[w + b];
        else k = 0;
    end else if (!ram_only) begin
      if (w == GPIO_ADDR)       v = mgpio;
      else if (w == TX_ADDR)    v = (32'(mfifo.size()) << 8) | ((mfifo.size() == DEPTH) ? 32'd2 : 32'd0)
                                    | ((mfifo.size() == 0) ? 32'd1 : 32'd0);
      else if (w == CYCLE_ADDR) v = mcyc;
      else if (w == DROPS_ADDR) v = mdrops;
    end
  endfunction

  task automatic step(input bit rst, input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] wd, input logic [3:0] ws, input bit rdy);
    exp_t e;
    logic [31:0] w;
    int pre_n;
    bit forced;
    @(posedge clk); #1;
    reset = rst;
    bus.imem_addr = ia; bus.dmem_addr = da; bus.dmem_wdata = wd;
    bus.dmem_wstrb = ws; bus.tx_ready = rdy;
    forced = do_force;
    if (do_force) begin
      force dut.cycle_cnt = 32'hFFFF_FFFE;
      mcyc = 32'hFFFF_FFFE;
      do_force = 0;
    end
    e.tag = edges + 1;
    w = {da[31:2], 2'b00};
    if (rst) begin
      e.im = NOP_INSTR; e.imk = 1; e.dm = '0; e.dmk = 1;
      mfifo.delete(); mgpio = 0; mcyc = 0; mdrops = 0;
    end else begin
      mread(ia, 1, e.im, e.imk);
      mread(da, 0, e.dm, e.dmk);
      if (da < RAM_BYTES) begin
        for (int b = 0; b < 4; b++) if (ws[b]) mbyte[w + b] = wd[8*b +: 8];
      end else if (w == GPIO_ADDR) begin
        for (int b = 0; b < 4; b++) if (ws[b]) mgpio[8*b +: 8] = wd[8*b +: 8];
      end
      pre_n = mfifo.size();
      if (pre_n > 0 && rdy) void'(mfifo.pop_front());
      if (w == TX_ADDR && ws[0]) begin
        if (pre_n == DEPTH) begin
          if (mdrops != 32'hFFFF_FFFF) mdrops++;
        end else mfifo.push_back(wd[7:0]);
      end
      mcyc++;
    end
    e.gp = mgpio;
    e.tv = mfifo.size() > 0;
    e.td = (mfifo.size() > 0) ? mfifo[0] : 8'h00;
    q.push_back(e);
    if (forced) begin
      #1 release dut.cycle_cnt;
    end
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, IDLE, 0, 0, rdy);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #3;
      while (q.size() > 0 && q[0].tag <= edges) begin
        e = q.pop_front();
        if (e.tag == edges) begin
          if (e.imk) chk("imem_rdata", bus.imem_rdata, e.im);
          if (e.dmk) chk("dmem_rdata", bus.dmem_rdata, e.dm);
          chk("gpio_out", bus.gpio_out, e.gp);
          chk("tx_valid", 32'(bus.tx_valid), 32'(e.tv));
          chk("tx_data", 32'(bus.tx_data), 32'(e.td));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1;
    bus.imem_addr = 0; bus.dmem_addr = IDLE; bus.dmem_wdata = 0;
    bus.dmem_wstrb = 0; bus.tx_ready = 0;
    repeat (3) step(1, 0, IDLE, 0, 0, 0);

    // boot word, then a write attempted under reset must not land
    step(0, 0, 32'h0, 32'h0050_0093, 4'hF, 0);
    step(0, 0, 32'h4, 32'h1111_1111, 4'hF, 0);
    step(1, 0, 32'h4, 32'h2222_2222, 4'hF, 0);
    step(1, 0, IDLE, 0, 0, 0);
    idle(0);
    step(0, 0, 32'h4, 0, 0, 0);

    // read-first on same-word write, including the fetch port
    step(0, 32'h10, 32'h10, 32'hAABB_CCDD, 4'hF, 0);
    step(0, 32'h10, 32'h10, 32'h0000_00EE, 4'h1, 0);
    step(0, 32'h10, 32'h13, 0, 0, 0);

    // GPIO lane strobes, unmapped write/read
    step(0, 0, GPIO_ADDR, 32'h1234_5678, 4'b0101, 0);
    step(0, 0, GPIO_ADDR, 0, 0, 0);
    step(0, 0, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, 0);
    step(0, 0, 32'h9000_0000, 0, 0, 0);

    // fill past full with consumer stalled
    for (int i = 0; i <= 16; i++) step(0, 0, TX_ADDR, i, 4'h1, 0);
    step(0, 0, TX_ADDR, 0, 0, 0);
    step(0, 0, DROPS_ADDR, 0, 0, 0);
    // push + pop while full: push dropped
    step(0, 0, TX_ADDR, 32'h55, 4'h1, 1);
    step(0, 0, DROPS_ADDR, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 0, TX_ADDR, 0, 0, 1);

    // cycle counter spacing and wrap
    step(0, 0, CYCLE_ADDR, 0, 0, 0);
    repeat (9) idle(0);
    step(0, 0, CYCLE_ADDR, 0, 0, 0);
    do_force = 1;
    repeat (3) step(0, 0, CYCLE_ADDR, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [3:0]  s;
      case ($urandom_range(0, 6))
        0, 1:    a = $urandom_range(0, 63);
        2:       a = GPIO_ADDR;
        3, 4:    a = TX_ADDR;
        5:       a = ($urandom_range(0, 1) != 0) ? CYCLE_ADDR : DROPS_ADDR;
        default: a = $urandom() | 32'h9000_0000;
      endcase
      s = ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'h0;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 63), a, $urandom(), s,
           $urandom_range(0, 2) != 0);
    end

    repeat (2) idle(1);
    @(posedge clk); @(posedge clk); #5;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
